// File: rtl/sdly_var_pkg.sv
// Common utilities shared by the delay-line blocks.
package sdly_var_pkg;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sdly_stage.sv
// One register stage of the delay line with async reset, enable and sync flush.
module sdly_stage #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (flush) begin
            q <= '0;
        end else if (ce) begin
            q <= d;
        end
    end

endmodule

// File: rtl/sdly_var.sv
// Variable-length delay line: DEPTH enabled stages with a runtime-selectable tap.
module sdly_var
    import sdly_var_pkg::*;
#(
    parameter  int WIDTH = 1,
    parameter  int DEPTH = 16,
    localparam int DW    = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             flush,
    input  logic [DW-1:0]    dly,
    input  logic [WIDTH-1:0] a,
    input  logic             a_vld,
    output logic [WIDTH-1:0] y,
    output logic             y_vld,
    output logic             primed
);

    localparam logic [DW-1:0] DEPTH_W = DW'(DEPTH);

    // s[0] is the live input so that a tap of zero is simply a pass-through.
    logic [WIDTH:0] s [0:DEPTH];
    logic [DW-1:0]  dly_eff;
    logic [DW-1:0]  cnt;
    logic [WIDTH:0] tap;

    assign s[0] = {a_vld, a};

    for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
        sdly_stage #(
            .W(WIDTH + 1)
        ) u_stage (
            .clk  (clk),
            .rst  (rst),
            .ce   (ce),
            .flush(flush),
            .d    (s[k-1]),
            .q    (s[k])
        );
    end

    always_comb begin
        dly_eff = (dly > DEPTH_W) ? DEPTH_W : dly;
        tap     = s[dly_eff];
    end

    assign y      = tap[WIDTH-1:0];
    assign y_vld  = tap[WIDTH];
    assign primed = (cnt >= dly_eff);

    // Fill count saturates so primed stays valid on arbitrarily long streams.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else if (ce && (cnt != DEPTH_W)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sdly_var.sv
// Directed self-checking bench for sdly_var with WIDTH=8, DEPTH=4.
module tb_sdly_var;

    logic       clk;
    logic       rst;
    logic       ce;
    logic       flush;
    logic [2:0] dly;
    logic [7:0] a;
    logic       a_vld;
    logic [7:0] y;
    logic       y_vld;
    logic       primed;

    int checks;
    int errors;

    typedef struct packed {
        logic       ce;
        logic       flush;
        logic [2:0] dly;
        logic [7:0] a;
        logic       a_vld;
        logic [7:0] ey;
        logic       ev;
        logic       ep;
    } vec_t;

    vec_t vecs [15];

    sdly_var #(
        .WIDTH(8),
        .DEPTH(4)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .ce    (ce),
        .flush (flush),
        .dly   (dly),
        .a     (a),
        .a_vld (a_vld),
        .y     (y),
        .y_vld (y_vld),
        .primed(primed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic c, input logic f, input logic [2:0] d,
                                input logic [7:0] av, input logic v,
                                input logic [7:0] ey, input logic ev, input logic ep);
        vec_t r;
        r.ce = c; r.flush = f; r.dly = d; r.a = av; r.a_vld = v;
        r.ey = ey; r.ev = ev; r.ep = ep;
        return r;
    endfunction

    // Inputs change on the falling edge; outputs are sampled 2 time units later.
    task automatic apply_stimulus(input logic c, input logic f, input logic [2:0] d,
                                  input logic [7:0] av, input logic v);
        @(negedge clk);
        ce = c; flush = f; dly = d; a = av; a_vld = v;
        #2;
    endtask

    task automatic check_output(input string name, input logic [7:0] ey,
                                input logic ev, input logic ep);
        checks++;
        if (y !== ey) begin
            errors++;
            $display("[TB] FAIL %s y got %h want %h", name, y, ey);
        end
        checks++;
        if (y_vld !== ev) begin
            errors++;
            $display("[TB] FAIL %s y_vld got %b want %b", name, y_vld, ev);
        end
        checks++;
        if (primed !== ep) begin
            errors++;
            $display("[TB] FAIL %s primed got %b want %b", name, primed, ep);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        ce = 1'b0; flush = 1'b0;
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] tog_y [8];
        logic       tog_v [8];
        logic [7:0] ey;

        checks = 0;
        errors = 0;
        rst = 1'b0; ce = 1'b0; flush = 1'b0; dly = 3'd3; a = 8'h00; a_vld = 1'b0;

        vecs[0]  = mk(1, 0, 3'd3, 8'h11, 1, 8'h00, 0, 0);
        vecs[1]  = mk(1, 0, 3'd3, 8'h22, 1, 8'h00, 0, 0);
        vecs[2]  = mk(1, 0, 3'd3, 8'h33, 1, 8'h00, 0, 0);
        vecs[3]  = mk(1, 0, 3'd3, 8'h44, 1, 8'h11, 1, 1);
        vecs[4]  = mk(1, 0, 3'd3, 8'h55, 0, 8'h22, 1, 1);
        vecs[5]  = mk(1, 0, 3'd0, 8'h66, 1, 8'h66, 1, 1);
        vecs[6]  = mk(1, 0, 3'd2, 8'h77, 1, 8'h55, 0, 1);
        vecs[7]  = mk(1, 0, 3'd7, 8'h88, 1, 8'h44, 1, 1);
        vecs[8]  = mk(0, 0, 3'd4, 8'h99, 1, 8'h55, 0, 1);
        vecs[9]  = mk(0, 0, 3'd7, 8'hAA, 1, 8'h55, 0, 1);
        vecs[10] = mk(1, 1, 3'd1, 8'hBB, 1, 8'h88, 1, 1);
        vecs[11] = mk(1, 0, 3'd1, 8'hCC, 1, 8'h00, 0, 0);
        vecs[12] = mk(0, 0, 3'd1, 8'hDD, 1, 8'hCC, 1, 1);
        vecs[13] = mk(0, 0, 3'd2, 8'hDD, 1, 8'h00, 0, 0);
        vecs[14] = mk(0, 0, 3'd0, 8'hEE, 0, 8'hEE, 0, 1);

        tog_y = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h10, 8'h12, 8'h12, 8'h14};
        tog_v = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        // Reset state for both a real tap and the pass-through tap.
        #1 rst = 1'b1;
        #1;
        dly = 3'd3; a = 8'h5C; a_vld = 1'b1;
        #1 check_output("reset_dly3", 8'h00, 1'b0, 1'b0);
        dly = 3'd0; a = 8'hA5; a_vld = 1'b1;
        #1 check_output("reset_dly0", 8'hA5, 1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            apply_stimulus(vecs[i].ce, vecs[i].flush, vecs[i].dly, vecs[i].a, vecs[i].a_vld);
            check_output($sformatf("vec%0d", i), vecs[i].ey, vecs[i].ev, vecs[i].ep);
        end

        // Clock enable toggling with dly=2.
        do_reset();
        for (int t = 0; t < 8; t++) begin
            apply_stimulus(((t % 2) == 0), 1'b0, 3'd2, 8'h10 + 8'(t), 1'b1);
            check_output($sformatf("ce_toggle%0d", t), tog_y[t], tog_v[t], tog_v[t]);
        end

        // Oversized dly clamps to DEPTH; count must saturate rather than wrap.
        do_reset();
        for (int n = 0; n < 10; n++) begin
            ey = (n >= 4) ? (8'h20 + 8'(n - 4)) : 8'h00;
            apply_stimulus(1'b1, 1'b0, 3'd7, 8'h20 + 8'(n), 1'b1);
            check_output($sformatf("sat%0d", n), ey, (n >= 4), (n >= 4));
        end
        apply_stimulus(1'b0, 1'b0, 3'd7, 8'h00, 1'b0);
        check_output("sat_dly7", 8'h26, 1'b1, 1'b1);
        dly = 3'd4;
        #1 check_output("sat_dly4", 8'h26, 1'b1, 1'b1);
        dly = 3'd3;
        #1 check_output("sat_dly3", 8'h27, 1'b1, 1'b1);

        // Asynchronous reset between edges while the line is full.
        #1 rst = 1'b1;
        #1 check_output("async_rst_dly3", 8'h00, 1'b0, 1'b0);
        dly = 3'd0; a = 8'h5A; a_vld = 1'b1;
        #1 check_output("async_rst_dly0", 8'h5A, 1'b1, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        apply_stimulus(1'b1, 1'b0, 3'd1, 8'h5A, 1'b1);
        check_output("refill0", 8'h00, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 3'd1, 8'h6B, 1'b1);
        check_output("refill1", 8'h5A, 1'b1, 1'b1);
        apply_stimulus(1'b0, 1'b0, 3'd2, 8'h00, 1'b0);
        check_output("refill2", 8'h5A, 1'b1, 1'b1);
        apply_stimulus(1'b0, 1'b0, 3'd3, 8'h00, 1'b0);
        check_output("refill3", 8'h00, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
